// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared rv32i pipeline types used by the stall/flush controller.
package rv32i_types;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] rv32i_reg;

  // Per-memory-side wait tracker state
  typedef enum logic {
    M_IDLE = 1'b0,
    M_DONE = 1'b1
  } mem_track_state_t;

endpackage

// File: rtl/mem_wait_tracker.sv
// Remembers a memory response that arrived while the pipeline was frozen,
// so the access counts as complete and is not re-issued until the pipeline moves.
module mem_wait_tracker
  import rv32i_types::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic resp,
  input  logic advance,
  output logic done,
  output logic req_en
);

  mem_track_state_t state_q;

  // Latch a completed access while frozen; release it when the pipeline advances
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= M_IDLE;
    end else if (state_q == M_IDLE) begin
      if (req && resp && !advance) begin
        state_q <= M_DONE;
      end
    end else begin
      if (advance) begin
        state_q <= M_IDLE;
      end
    end
  end

  // Effective completion and request gating; a response during reset is ignored
  assign done   = !rst && (resp || (state_q == M_DONE));
  assign req_en = !rst && (state_q != M_DONE);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage rv32i pipeline: memory freeze,
// taken-branch flush, load-use bubble, plus performance counters.
module pipeline_stall_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  rv32i_reg         IFID_rs1,
  input  rv32i_reg         IFID_rs2,
  input  logic             IFID_uses_rs1,
  input  logic             IFID_uses_rs2,
  input  rv32i_reg         IDEX_rd,
  input  logic             IDEX_mem_read,
  input  logic             EX_br_taken,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             imem_read_en,
  output logic             dmem_req_en,
  output logic             load_pc,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exmem,
  output logic             load_memwb,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  logic imem_done;
  logic dmem_done;
  logic freeze;
  logic advance;
  logic load_use;
  logic sel_flush;
  logic sel_bubble;

  logic [CNT_W-1:0] stall_q,  stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] flush_q,  flush_d;

  mem_wait_tracker u_imem_trk (
    .clk     (clk),
    .rst     (rst),
    .req     (imem_read),
    .resp    (imem_resp),
    .advance (advance),
    .done    (imem_done),
    .req_en  (imem_read_en)
  );

  mem_wait_tracker u_dmem_trk (
    .clk     (clk),
    .rst     (rst),
    .req     (dmem_req),
    .resp    (dmem_resp),
    .advance (advance),
    .done    (dmem_done),
    .req_en  (dmem_req_en)
  );

  // Hazard detection; x0 never creates a load-use dependency
  always_comb begin
    freeze   = (imem_read && !imem_done) || (dmem_req && !dmem_done);
    advance  = !freeze;
    load_use = IDEX_mem_read && (IDEX_rd != REG_W'(0)) &&
               ((IFID_uses_rs1 && (IFID_rs1 == IDEX_rd)) ||
                (IFID_uses_rs2 && (IFID_rs2 == IDEX_rd)));
    sel_flush  = !rst && !freeze && EX_br_taken;
    sel_bubble = !rst && !freeze && !EX_br_taken && load_use;
  end

  // Pipeline register control: reset > freeze > taken branch > load-use > normal
  always_comb begin
    load_pc     = 1'b1;
    load_ifid   = 1'b1;
    load_idex   = 1'b1;
    load_exmem  = 1'b1;
    load_memwb  = 1'b1;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    if (rst) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (freeze) begin
      load_pc    = 1'b0;
      load_ifid  = 1'b0;
      load_idex  = 1'b0;
      load_exmem = 1'b0;
      load_memwb = 1'b0;
    end else if (EX_br_taken) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (load_use) begin
      load_pc     = 1'b0;
      load_ifid   = 1'b0;
      bubble_idex = 1'b1;
    end
  end

  // Counter next-state; wraps naturally at CNT_W bits
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    flush_d  = flush_q;
    if (!rst && freeze) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (sel_bubble) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
    if (sel_flush) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_count = bubble_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned CNT_W = 32;

  // Flag order: {imem_en, dmem_en, pc, ifid, idex, exmem, memwb, flush, bubble}
  localparam logic [8:0] F_RUN   = 9'b11_11111_00;
  localparam logic [8:0] F_FRZ   = 9'b11_00000_00;
  localparam logic [8:0] F_BR    = 9'b11_11111_11;
  localparam logic [8:0] F_LU    = 9'b11_00111_01;
  localparam logic [8:0] F_RST   = 9'b00_11111_11;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
  logic IFID_uses_rs1, IFID_uses_rs2, IDEX_mem_read, EX_br_taken;
  logic imem_read, imem_resp, dmem_req, dmem_resp;
  logic imem_read_en, dmem_req_en, load_pc, load_ifid, load_idex;
  logic load_exmem, load_memwb, flush_ifid, bubble_idex;
  logic [CNT_W-1:0] stall_cycles, bubble_count, flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: "access already completed" per side plus event totals
  bit          m_igot, m_dgot;
  int unsigned m_stall, m_bubble, m_flush;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, br, ir, iresp, dr, dresp;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IFID_uses_rs1(IFID_uses_rs1), .IFID_uses_rs2(IFID_uses_rs2),
    .IDEX_rd(IDEX_rd), .IDEX_mem_read(IDEX_mem_read),
    .EX_br_taken(EX_br_taken),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .imem_read_en(imem_read_en), .dmem_req_en(dmem_req_en),
    .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
    .load_exmem(load_exmem), .load_memwb(load_memwb),
    .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count),
    .flush_count(flush_count)
  );

  function automatic logic [8:0] dut_flags();
    return {imem_read_en, dmem_req_en, load_pc, load_ifid, load_idex,
            load_exmem, load_memwb, flush_ifid, bubble_idex};
  endfunction

  // Behavioural view of the current cycle
  function automatic bit m_hazard();
    return IDEX_mem_read && (IDEX_rd != 5'd0) &&
           ((IFID_uses_rs1 && IFID_rs1 == IDEX_rd) ||
            (IFID_uses_rs2 && IFID_rs2 == IDEX_rd));
  endfunction

  function automatic bit m_frozen();
    bit iwait, dwait;
    iwait = imem_read && !(imem_resp || m_igot);
    dwait = dmem_req  && !(dmem_resp || m_dgot);
    return iwait || dwait;
  endfunction

  function automatic logic [8:0] m_flags();
    logic [1:0] en;
    en = {~m_igot, ~m_dgot};
    if (rst)              return F_RST;
    if (m_frozen())       return {en, 7'b00000_00};
    if (EX_br_taken)      return {en, 7'b11111_11};
    if (m_hazard())       return {en, 7'b00111_01};
    return {en, 7'b11111_00};
  endfunction

  task automatic check_val(input string name, input logic [CNT_W-1:0] got,
                           input logic [CNT_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, then clocks the model
  task automatic run_cycle(input string name, input bit use_exp, input logic [8:0] exp);
    bit fz, hz;
    #3;
    check_val({name, " flags/model"}, CNT_W'(dut_flags()), CNT_W'(m_flags()));
    if (use_exp) check_val({name, " flags/table"}, CNT_W'(dut_flags()), CNT_W'(exp));
    check_val({name, " stall_cycles"}, stall_cycles, CNT_W'(m_stall));
    check_val({name, " bubble_count"}, bubble_count, CNT_W'(m_bubble));
    check_val({name, " flush_count"},  flush_count,  CNT_W'(m_flush));
    fz = m_frozen();
    hz = m_hazard();
    if (rst) begin
      m_igot = 0; m_dgot = 0;
      m_stall = 0; m_bubble = 0; m_flush = 0;
    end else if (!fz) begin
      m_igot = 0; m_dgot = 0;
      if (EX_br_taken) m_flush++;
      else if (hz)     m_bubble++;
    end else begin
      m_igot = m_igot || (imem_read && imem_resp);
      m_dgot = m_dgot || (dmem_req && dmem_resp);
      m_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0;
    IFID_rs1 = 0; IFID_rs2 = 0; IDEX_rd = 0;
    IFID_uses_rs1 = 0; IFID_uses_rs2 = 0; IDEX_mem_read = 0; EX_br_taken = 0;
    imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    run_cycle("reset", 1, F_RST);
    rst = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    IFID_rs1 = v.rs1; IFID_rs2 = v.rs2; IDEX_rd = v.rd;
    IFID_uses_rs1 = v.u1; IFID_uses_rs2 = v.u2;
    IDEX_mem_read = v.mr; EX_br_taken = v.br;
    imem_read = v.ir; imem_resp = v.iresp; dmem_req = v.dr; dmem_resp = v.dresp;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_igot = 0; m_dgot = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();

    // rs1 rs2 rd u1 u2 mr br ir iresp dr dresp exp
    vecs.push_back('{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 1, 1, 0, 0, F_LU});
    vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 1, 1, 0, 0, F_RUN});
    vecs.push_back('{5'd7, 5'd1, 5'd7, 1, 0, 1, 0, 1, 1, 0, 0, F_LU});
    vecs.push_back('{5'd7, 5'd1, 5'd7, 0, 1, 1, 0, 1, 1, 0, 0, F_RUN});
    vecs.push_back('{5'd7, 5'd7, 5'd7, 1, 1, 0, 0, 1, 1, 0, 0, F_RUN});
    vecs.push_back('{5'd3, 5'd3, 5'd3, 1, 1, 1, 1, 1, 1, 0, 0, F_BR});
    vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, F_FRZ});
    vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, F_FRZ});
    vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 1, 1, F_RUN});
    vecs.push_back('{5'd4, 5'd0, 5'd4, 1, 0, 1, 1, 1, 0, 0, 0, F_FRZ});
    vecs.push_back('{5'd9, 5'd9, 5'd2, 1, 1, 1, 0, 0, 0, 0, 0, F_RUN});
    vecs.push_back('{5'd31, 5'd2, 5'd31, 1, 1, 1, 0, 0, 0, 1, 1, F_LU});
    foreach (vecs[i]) begin
      apply_vec(vecs[i]);
      run_cycle($sformatf("vec%0d", i), 1, vecs[i].exp);
    end

    // Load-use then branch-over-load-use with fresh counters
    do_reset();
    apply_vec('{5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 1, 1, 1, 1, F_LU});
    run_cycle("lu", 1, F_LU);
    idle_inputs();
    run_cycle("lu after", 1, F_RUN);
    check_val("lu bubble_count", bubble_count, CNT_W'(1));
    apply_vec('{5'd0, 5'd5, 5'd5, 0, 1, 1, 1, 1, 1, 0, 0, F_BR});
    run_cycle("br+lu", 1, F_BR);
    idle_inputs();
    run_cycle("br after", 1, F_RUN);
    check_val("br flush_count", flush_count, CNT_W'(1));
    check_val("br bubble_count", bubble_count, CNT_W'(1));

    // dmem miss: four frozen cycles, then advance on the response
    do_reset();
    dmem_req = 1;
    for (int c = 0; c < 4; c++) run_cycle("dmiss wait", 1, F_FRZ);
    dmem_resp = 1;
    run_cycle("dmiss resp", 1, F_RUN);
    idle_inputs();
    run_cycle("dmiss after", 1, F_RUN);
    check_val("dmiss stall_cycles", stall_cycles, CNT_W'(4));

    // Split responses: imem at cycle 2, dmem at cycle 5
    do_reset();
    imem_read = 1; dmem_req = 1;
    run_cycle("split c1", 1, F_FRZ);
    imem_resp = 1;
    run_cycle("split c2", 1, F_FRZ);
    imem_resp = 0;
    run_cycle("split c3", 1, 9'b01_00000_00);
    run_cycle("split c4", 1, 9'b01_00000_00);
    dmem_resp = 1;
    run_cycle("split c5", 1, 9'b01_11111_00);
    dmem_resp = 0;
    run_cycle("split c6", 1, F_FRZ);
    idle_inputs();
    run_cycle("split c7", 1, F_RUN);

    // Taken branch held through a 3-cycle dmem freeze
    do_reset();
    dmem_req = 1; EX_br_taken = 1;
    for (int c = 0; c < 3; c++) run_cycle("brfrz wait", 1, F_FRZ);
    dmem_resp = 1;
    run_cycle("brfrz adv", 1, F_BR);
    idle_inputs();
    run_cycle("brfrz after", 1, F_RUN);
    check_val("brfrz flush_count", flush_count, CNT_W'(1));

    // Reset while the imem tracker holds a completed access
    do_reset();
    imem_read = 1; imem_resp = 1; dmem_req = 1;
    run_cycle("rstdone latch", 1, F_FRZ);
    imem_resp = 0;
    run_cycle("rstdone held", 1, 9'b01_00000_00);
    rst = 1; imem_resp = 1;
    run_cycle("rstdone rst", 1, F_RST);
    rst = 0; imem_resp = 0; dmem_req = 0;
    run_cycle("rstdone after", 1, F_FRZ);
    check_val("rstdone stall_cycles", stall_cycles, CNT_W'(1));

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      IFID_rs1      = 5'($urandom_range(0, 3));
      IFID_rs2      = 5'($urandom_range(0, 3));
      IDEX_rd       = 5'($urandom_range(0, 3));
      IFID_uses_rs1 = 1'($urandom_range(0, 1));
      IFID_uses_rs2 = 1'($urandom_range(0, 1));
      IDEX_mem_read = 1'($urandom_range(0, 1));
      EX_br_taken   = ($urandom_range(0, 4) == 0);
      imem_read     = ($urandom_range(0, 3) != 0);
      imem_resp     = 1'($urandom_range(0, 1));
      dmem_req      = 1'($urandom_range(0, 1));
      dmem_resp     = ($urandom_range(0, 2) == 0);
      run_cycle("rand", 0, 9'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Stall/flush controller for the 5-stage rv32i pipeline. It covers the hazards that operand forwarding cannot resolve.
- Detects load-use hazards and inserts a bubble into ID/EX.
- Flushes wrong-path instructions when a branch or jump is taken in EX.
- Freezes the entire pipeline while the instruction or data memory has not responded, and tracks completed responses so a frozen access is never re-issued.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- IFID_rs1  in  5 (rv32i_reg)  rs1 of the instruction in ID
- IFID_rs2  in  5 (rv32i_reg)  rs2 of the instruction in ID
- IFID_uses_rs1  in  1  ID instruction reads rs1
- IFID_uses_rs2  in  1  ID instruction reads rs2
- IDEX_rd  in  5 (rv32i_reg)  destination register of the instruction in EX
- IDEX_mem_read  in  1  EX instruction is a load
- EX_br_taken  in  1  branch/jump in EX resolved taken
- imem_read  in  1  IF stage requests a fetch
- imem_resp  in  1  instruction memory response
- dmem_req  in  1  MEM stage requests a read or write
- dmem_resp  in  1  data memory response
- imem_read_en  out  1  gate ANDed onto the fetch request
- dmem_req_en  out  1  gate ANDed onto the data request
- load_pc  out  1  PC register enable
- load_ifid  out  1  IF/ID register enable
- load_idex  out  1  ID/EX register enable
- load_exmem  out  1  EX/MEM register enable
- load_memwb  out  1  MEM/WB register enable
- flush_ifid  out  1  load a NOP into IF/ID
- bubble_idex  out  1  load a NOP (all control signals zero) into ID/EX
- stall_cycles  out  CNT_W  count of freeze cycles
- bubble_count  out  CNT_W  count of load-use bubbles
- flush_count  out  CNT_W  count of taken-branch flushes

Behaviour:
- Memory tracker, one per memory side. States: M_IDLE, M_DONE.
  - M_IDLE to M_DONE: request asserted, response asserted, and the pipeline does not advance this cycle.
  - M_DONE to M_IDLE: on the cycle the pipeline advances.
  - Effective completion: done = resp OR (state == M_DONE).
  - Request gate: the *_en output is 0 in M_DONE, 1 otherwise, so a completed access is not re-issued while frozen.
- Freeze condition: freeze = (imem_read AND NOT imem_done) OR (dmem_req AND NOT dmem_done). advance = NOT freeze.
- Load-use condition:
  - lu = IDEX_mem_read AND IDEX_rd != 0 AND ((IFID_uses_rs1 AND IFID_rs1 == IDEX_rd) OR (IFID_uses_rs2 AND IFID_rs2 == IDEX_rd)).
  - x0 never causes a hazard.
- Priority, evaluated combinationally each cycle:
  - freeze: all load_* = 0; flush_ifid = 0; bubble_idex = 0.
  - else if EX_br_taken: all load_* = 1; flush_ifid = 1; bubble_idex = 1. Branch wins over lu because the ID instruction is wrong-path; no bubble is counted.
  - else if lu: load_pc = 0; load_ifid = 0; load_idex = 1; bubble_idex = 1; load_exmem = 1; load_memwb = 1.
  - else: all load_* = 1; flush_ifid = 0; bubble_idex = 0.
- Branch during a freeze: no latch is needed, because EX holds and EX_br_taken remains asserted. The flush takes effect on the first advance cycle.
- Latency: hazard decisions are zero-cycle (combinational from inputs). Tracker state updates on the clk edge.
- Counters: registered, wrap modulo 2^CNT_W.
  - stall_cycles increments on every freeze cycle.
  - bubble_count increments on lu-selected cycles.
  - flush_count increments on branch-selected cycles.
- Reset (synchronous, rst = 1 at the clk edge):
  - Both trackers go to M_IDLE; all counters go to 0.
  - Outputs during reset: all load_* = 1; flush_ifid = 1; bubble_idex = 1; *_en = 0. The pipeline registers therefore load NOPs.
  - Reset mid-wait discards a latched M_DONE. Any in-flight response arriving in the reset cycle is ignored.
- Simultaneous responses: both responses in the same cycle lead to advance, and neither tracker enters M_DONE. A response arriving while the tracker is already in M_DONE is ignored.

Decomposition:
- Package (rv32i_types): mem_track_state_t enum {M_IDLE, M_DONE}.
- Sub-module mem_wait_tracker, instantiated twice.
  - Ports: clk, rst, req, resp, advance, done, req_en.
- Hazard priority logic and counters stay at top level.

Test Plan:
- Load-use: IDEX_mem_read = 1, IDEX_rd = 5; IFID_rs2 = 5 with uses_rs2 = 1; memories respond immediately -> one cycle with load_pc = 0, load_ifid = 0, bubble_idex = 1, load_exmem = 1; bubble_count = 1. Repeat with IDEX_rd = 0 -> no stall.
- Taken branch with lu also true -> flush_ifid = 1, bubble_idex = 1, load_pc = 1; flush_count = 1; bubble_count unchanged.
- dmem miss: dmem_req = 1 held; dmem_resp after 4 cycles -> 4 freeze cycles with all load_* = 0; stall_cycles = 4; advance on the resp cycle.
- Split responses: imem_resp at cycle 2, dmem_resp at cycle 5 -> imem tracker enters M_DONE at cycle 2; imem_read_en = 0 for cycles 3-5; single advance at cycle 5; tracker returns to M_IDLE.
- Branch taken during a 3-cycle dmem freeze -> no flush while frozen; flush_ifid = 1 exactly on the advance cycle.
- Reset asserted while imem tracker is in M_DONE -> next cycle tracker is M_IDLE, counters = 0, imem_read_en = 1 after rst deasserts.
